// File: rtl/blit_pkg.sv
// -----------------------------------------------------------------------------
// blit_pkg
// Constants and types shared by the sprite blitter and the VGA adapter
// instance: default screen geometry and colour width, command mode codes, the
// blitter state encoding and the scan-order selector used by the scan
// generator.
// -----------------------------------------------------------------------------
package blit_pkg;

  // Default framebuffer geometry and colour format (5:5:5).
  localparam int unsigned SCR_W_DEF = 320;
  localparam int unsigned SCR_H_DEF = 240;
  localparam int unsigned XW_DEF    = 9;
  localparam int unsigned YW_DEF    = 8;
  localparam int unsigned CW_DEF    = 15;

  // Command modes presented on the mode input.
  localparam logic [1:0] MODE_CLEAR = 2'd0;
  localparam logic [1:0] MODE_BLIT  = 2'd1;
  localparam logic [1:0] MODE_TILE  = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } blit_state_e;

  // Scan order: full-screen raster, one sprite, or a sprite per screen tile.
  typedef enum logic [1:0] {
    SCAN_RASTER = 2'd0,
    SCAN_SPRITE = 2'd1,
    SCAN_TILE   = 2'd2
  } scan_mode_e;

  function automatic int unsigned ceil_div(input int unsigned num,
                                           input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/blit_scan_gen.sv
// -----------------------------------------------------------------------------
// blit_scan_gen
// Nested scan counters for the blitter. In raster order cx/cy walk the whole
// screen with cx fastest. In sprite order px/py walk one sprite with px
// fastest. In tile order every sprite scan is followed by a step of the tile
// counters tx/ty (tx fastest). last_o flags the final position of the
// selected scan so the caller can leave its run state on that step.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   restart_i      zero all counters (new command)
//   step_i         advance one position in the order given by scan_mode_i
//   scan_mode_i    raster / sprite / tile
//   px_o, py_o     position inside the sprite
//   tx_o, ty_o     current tile
//   cx_o, cy_o     raster position
//   last_o         current position is the last one of the scan
// -----------------------------------------------------------------------------
module blit_scan_gen
  import blit_pkg::*;
#(
  parameter int unsigned SCR_W = SCR_W_DEF,
  parameter int unsigned SCR_H = SCR_H_DEF,
  parameter int unsigned XW    = XW_DEF,
  parameter int unsigned YW    = YW_DEF,
  parameter int unsigned SPR_W = 16,
  parameter int unsigned SPR_H = 16,
  parameter int unsigned TX_N  = ceil_div(SCR_W, SPR_W),
  parameter int unsigned TY_N  = ceil_div(SCR_H, SPR_H),
  localparam int PXW = $clog2(SPR_W),
  localparam int PYW = $clog2(SPR_H),
  localparam int TXW = (TX_N > 1) ? $clog2(TX_N) : 1,
  localparam int TYW = (TY_N > 1) ? $clog2(TY_N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            restart_i,
  input  logic            step_i,
  input  scan_mode_e      scan_mode_i,
  output logic [PXW-1:0]  px_o,
  output logic [PYW-1:0]  py_o,
  output logic [TXW-1:0]  tx_o,
  output logic [TYW-1:0]  ty_o,
  output logic [XW-1:0]   cx_o,
  output logic [YW-1:0]   cy_o,
  output logic            last_o
);

  logic [PXW-1:0] px_q, px_d;
  logic [PYW-1:0] py_q, py_d;
  logic [TXW-1:0] tx_q, tx_d;
  logic [TYW-1:0] ty_q, ty_d;
  logic [XW-1:0]  cx_q, cx_d;
  logic [YW-1:0]  cy_q, cy_d;

  logic px_end, py_end, tx_end, ty_end, cx_end, cy_end;

  assign px_end = (px_q == PXW'(SPR_W - 1));
  assign py_end = (py_q == PYW'(SPR_H - 1));
  assign tx_end = (tx_q == TXW'(TX_N - 1));
  assign ty_end = (ty_q == TYW'(TY_N - 1));
  assign cx_end = (cx_q == XW'(SCR_W - 1));
  assign cy_end = (cy_q == YW'(SCR_H - 1));

  always_comb begin
    unique case (scan_mode_i)
      SCAN_RASTER: last_o = cx_end && cy_end;
      SCAN_SPRITE: last_o = px_end && py_end;
      default:     last_o = px_end && py_end && tx_end && ty_end;
    endcase
  end

  // NOTE: every signal written in an always_comb block gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    px_d = px_q;
    py_d = py_q;
    tx_d = tx_q;
    ty_d = ty_q;
    cx_d = cx_q;
    cy_d = cy_q;
    if (restart_i) begin
      px_d = '0;
      py_d = '0;
      tx_d = '0;
      ty_d = '0;
      cx_d = '0;
      cy_d = '0;
    end else if (step_i) begin
      if (scan_mode_i == SCAN_RASTER) begin
        if (cx_end) begin
          cx_d = '0;
          cy_d = cy_end ? '0 : cy_q + 1'b1;
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end else begin
        // Sprite dimensions are powers of two, so px/py wrap on their own.
        px_d = px_q + 1'b1;
        if (px_end) begin
          py_d = py_q + 1'b1;
          if (py_end && (scan_mode_i == SCAN_TILE)) begin
            if (tx_end) begin
              tx_d = '0;
              ty_d = ty_end ? '0 : ty_q + 1'b1;
            end else begin
              tx_d = tx_q + 1'b1;
            end
          end
        end
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q <= '0;
      py_q <= '0;
      tx_q <= '0;
      ty_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      px_q <= px_d;
      py_q <= py_d;
      tx_q <= tx_d;
      ty_q <= ty_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign px_o = px_q;
  assign py_o = py_q;
  assign tx_o = tx_q;
  assign ty_o = ty_q;
  assign cx_o = cx_q;
  assign cy_o = cy_q;

endmodule

// File: rtl/sprite_blitter.sv
// -----------------------------------------------------------------------------
// sprite_blitter
// Pixel engine feeding the VGA adapter one write per clock. Commands:
//   CLEAR  raster the whole screen with fill_colour (no ROM access)
//   BLIT   draw one sprite from the ROM with its origin at (base_x, base_y)
//   TILE   cover the screen with copies of one sprite, tile by tile
//   mode 3 reserved: a one-cycle busy then done, no writes
// BLIT/TILE pixels are clipped to the screen and, with transp_en, pixels whose
// ROM word equals KEY are suppressed; every scanned pixel still costs a cycle.
//
// Ports
//   clk, reset           clock, asynchronous active-low reset
//   start                command strobe, only sampled in IDLE
//   mode, base_x, base_y, sprite_sel, fill_colour, transp_en
//                        command fields, latched on an accepted start
//   rom_addr / rom_data  sprite ROM, address {sprite_sel, py, px}; data is
//                        consumed one cycle after the address is presented
//   busy, done           command in progress / one-cycle completion pulse
//   writeEn, X, Y, Colour  registered pixel write to the framebuffer
// -----------------------------------------------------------------------------
module sprite_blitter
  import blit_pkg::*;
#(
  parameter int unsigned SCR_W = SCR_W_DEF,
  parameter int unsigned SCR_H = SCR_H_DEF,
  parameter int unsigned XW    = XW_DEF,
  parameter int unsigned YW    = YW_DEF,
  parameter int unsigned CW    = CW_DEF,
  parameter int unsigned SPR_W = 16,
  parameter int unsigned SPR_H = 16,
  parameter int unsigned SEL_W = 2,
  parameter logic [CW-1:0] KEY = '0,
  localparam int PXW = $clog2(SPR_W),
  localparam int PYW = $clog2(SPR_H),
  localparam int AW  = SEL_W + PYW + PXW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [XW-1:0]    base_x,
  input  logic [YW-1:0]    base_y,
  input  logic [SEL_W-1:0] sprite_sel,
  input  logic [CW-1:0]    fill_colour,
  input  logic             transp_en,
  output logic [AW-1:0]    rom_addr,
  input  logic [CW-1:0]    rom_data,
  output logic             busy,
  output logic             done,
  output logic             writeEn,
  output logic [XW-1:0]    X,
  output logic [YW-1:0]    Y,
  output logic [CW-1:0]    Colour
);

  localparam int unsigned TX_N = ceil_div(SCR_W, SPR_W);
  localparam int unsigned TY_N = ceil_div(SCR_H, SPR_H);
  localparam int TXW = (TX_N > 1) ? $clog2(TX_N) : 1;
  localparam int TYW = (TY_N > 1) ? $clog2(TY_N) : 1;

  // Screen limits at the widened coordinate width used for clipping.
  localparam logic [XW:0] SCR_W_L = (XW + 1)'(SCR_W);
  localparam logic [YW:0] SCR_H_L = (YW + 1)'(SCR_H);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  blit_state_e      state_q;

  logic [1:0]       mode_q;
  logic [XW-1:0]    base_x_q;
  logic [YW-1:0]    base_y_q;
  logic [SEL_W-1:0] sel_q;
  logic [CW-1:0]    fill_q;
  logic             transp_q;

  logic             busy_q;
  logic             done_q;
  logic             we_q;
  logic [XW-1:0]    x_q;
  logic [YW-1:0]    y_q;
  logic [CW-1:0]    col_q;
  logic [AW-1:0]    rom_addr_q;

  // ROM-latency stage: screen coordinate of the pixel whose ROM word is being
  // read this cycle. Kept one bit wider so off-screen sums never wrap back on.
  logic             pix_vld_q;
  logic [XW:0]      pix_x_q;
  logic [YW:0]      pix_y_q;

  // ---------------------------------------------------------------------------
  // Scan counters
  // ---------------------------------------------------------------------------
  logic [PXW-1:0] px;
  logic [PYW-1:0] py;
  logic [TXW-1:0] tx;
  logic [TYW-1:0] ty;
  logic [XW-1:0]  cx;
  logic [YW-1:0]  cy;
  logic           scan_last;
  logic           scan_restart;
  logic           scan_step;
  scan_mode_e     scan_mode;

  assign scan_restart = (state_q == ST_IDLE) && start;
  assign scan_step    = (state_q == ST_RUN);

  always_comb begin
    unique case (mode_q)
      MODE_CLEAR: scan_mode = SCAN_RASTER;
      MODE_TILE:  scan_mode = SCAN_TILE;
      default:    scan_mode = SCAN_SPRITE;
    endcase
  end

  blit_scan_gen #(
    .SCR_W (SCR_W),
    .SCR_H (SCR_H),
    .XW    (XW),
    .YW    (YW),
    .SPR_W (SPR_W),
    .SPR_H (SPR_H),
    .TX_N  (TX_N),
    .TY_N  (TY_N)
  ) u_scan (
    .clk         (clk),
    .rst_n       (reset),
    .restart_i   (scan_restart),
    .step_i      (scan_step),
    .scan_mode_i (scan_mode),
    .px_o        (px),
    .py_o        (py),
    .tx_o        (tx),
    .ty_o        (ty),
    .cx_o        (cx),
    .cy_o        (cy),
    .last_o      (scan_last)
  );

  // ---------------------------------------------------------------------------
  // Screen coordinate of the pixel being addressed in the ROM
  // ---------------------------------------------------------------------------
  logic [XW:0] org_x, pix_x_d;
  logic [YW:0] org_y, pix_y_d;

  always_comb begin
    org_x = {1'b0, base_x_q};
    org_y = {1'b0, base_y_q};
    if (mode_q == MODE_TILE) begin
      org_x = (XW + 1)'(tx) << PXW;
      org_y = (YW + 1)'(ty) << PYW;
    end
    pix_x_d = org_x + (XW + 1)'(px);
    pix_y_d = org_y + (YW + 1)'(py);
  end

  // ---------------------------------------------------------------------------
  // Clipping and transparency on the pixel whose ROM word has arrived
  // ---------------------------------------------------------------------------
  logic in_bounds;
  logic keyed;
  logic pix_we;

  assign in_bounds = (pix_x_q < SCR_W_L) && (pix_y_q < SCR_H_L);
  assign keyed     = transp_q && (rom_data == KEY);
  assign pix_we    = pix_vld_q && in_bounds && !keyed;

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: the asynchronous reset clears the ROM-latency stage as well as the
  // outputs, so a reset in the middle of a command cannot leak a final write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_CLEAR;
      base_x_q   <= '0;
      base_y_q   <= '0;
      sel_q      <= '0;
      fill_q     <= '0;
      transp_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      col_q      <= '0;
      rom_addr_q <= '0;
      pix_vld_q  <= 1'b0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
    end else begin
      done_q    <= 1'b0;
      pix_vld_q <= 1'b0;

      // Write stage: the pixel addressed last cycle is emitted now. X/Y/Colour
      // follow it even when clipped or keyed; only writeEn is suppressed.
      we_q <= 1'b0;
      if (pix_vld_q) begin
        we_q  <= pix_we;
        x_q   <= pix_x_q[XW-1:0];
        y_q   <= pix_y_q[YW-1:0];
        col_q <= rom_data;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_q   <= mode;
            base_x_q <= base_x;
            base_y_q <= base_y;
            sel_q    <= sprite_sel;
            fill_q   <= fill_colour;
            transp_q <= transp_en;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end
        end

        ST_RUN: begin
          case (mode_q)
            MODE_CLEAR: begin
              // No ROM involved, so the write goes out directly.
              we_q  <= 1'b1;
              x_q   <= cx;
              y_q   <= cy;
              col_q <= fill_q;
              if (scan_last) state_q <= ST_DRAIN;
            end
            MODE_BLIT, MODE_TILE: begin
              rom_addr_q <= {sel_q, py, px};
              pix_vld_q  <= 1'b1;
              pix_x_q    <= pix_x_d;
              pix_y_q    <= pix_y_d;
              if (scan_last) state_q <= ST_DRAIN;
            end
            default: begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          endcase
        end

        // Stay until the ROM-latency stage is empty, i.e. until the cycle in
        // which the last write is on the outputs has passed.
        ST_DRAIN: begin
          if (!pix_vld_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        ST_DONE: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign writeEn  = we_q;
  assign X        = x_q;
  assign Y        = y_q;
  assign Colour   = col_q;
  assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// -----------------------------------------------------------------------------
// tb_sprite_blitter
// Randomised scoreboard bench. A reference model derives, from the drawing
// rules alone, the ordered list of framebuffer writes each command should
// produce (coordinate, colour and cycle offset from the accepting edge) and
// queues it; a monitor pops and compares on every writeEn. The screen is
// shrunk to 72x40 (not a multiple of the sprite size) to keep CLEAR and TILE
// short while still exercising right/bottom tile clipping.
// -----------------------------------------------------------------------------
module tb_sprite_blitter;
  import blit_pkg::*;

  localparam int SCR_W = 72;
  localparam int SCR_H = 40;
  localparam int XW    = 9;
  localparam int YW    = 8;
  localparam int CW    = 15;
  localparam int SPR_W = 16;
  localparam int SPR_H = 16;
  localparam int SEL_W = 2;
  localparam int AW    = SEL_W + 8;
  localparam logic [CW-1:0] KEY = 15'h0000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       mode = '0;
  logic [XW-1:0]    base_x = '0;
  logic [YW-1:0]    base_y = '0;
  logic [SEL_W-1:0] sprite_sel = '0;
  logic [CW-1:0]    fill_colour = '0;
  logic             transp_en = 1'b0;
  logic [AW-1:0]    rom_addr;
  logic [CW-1:0]    rom_data;
  logic             busy, done, writeEn;
  logic [XW-1:0]    X;
  logic [YW-1:0]    Y;
  logic [CW-1:0]    Colour;

  logic [CW-1:0] rom [0:(1<<AW)-1];
  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  sprite_blitter #(
    .SCR_W(SCR_W), .SCR_H(SCR_H), .XW(XW), .YW(YW), .CW(CW),
    .SPR_W(SPR_W), .SPR_H(SPR_H), .SEL_W(SEL_W), .KEY(KEY)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .base_x(base_x), .base_y(base_y), .sprite_sel(sprite_sel),
    .fill_colour(fill_colour), .transp_en(transp_en),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy), .done(done), .writeEn(writeEn),
    .X(X), .Y(Y), .Colour(Colour)
  );

  typedef struct { int x; int y; int col; int delta; } pix_t;
  pix_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int base_cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write is matched against the head of the scoreboard,
  // including the cycle it appears relative to the accepting clock edge.
  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (writeEn) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got (%0d,%0d,%h) expected none",
                   X, Y, Colour);
        end else begin
          e = exp_q.pop_front();
          check("pixel", {16'(cyc - base_cyc), 16'(X), 16'(Y), 16'(Colour)},
                {16'(e.delta), 16'(e.x), 16'(e.y), 16'(e.col)});
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Reference model: one scanned sprite at (ox,oy); k counts scanned pixels.
  task automatic model_sprite(input int ox, input int oy, input int sel,
                              input bit tr, inout int k);
    logic [CW-1:0] c;
    for (int py = 0; py < SPR_H; py++)
      for (int px = 0; px < SPR_W; px++) begin
        c = rom[sel * SPR_W * SPR_H + py * SPR_W + px];
        if ((ox + px) < SCR_W && (oy + py) < SCR_H && !(tr && c == KEY))
          exp_q.push_back('{ox + px, oy + py, int'(c), 2 + k});
        k++;
      end
  endtask

  // Queues the expected writes; returns their count and the done latency.
  task automatic model_cmd(input logic [1:0] m, input int bx, input int by,
                           input int sel, input int fill, input bit tr,
                           output int n, output int lat);
    int k = 0;
    exp_q.delete();
    if (m == MODE_CLEAR) begin
      for (int y = 0; y < SCR_H; y++)
        for (int x = 0; x < SCR_W; x++) begin
          exp_q.push_back('{x, y, fill, 1 + k});
          k++;
        end
      lat = k + 1;
    end else if (m == MODE_BLIT) begin
      model_sprite(bx, by, sel, tr, k);
      lat = k + 2;
    end else if (m == MODE_TILE) begin
      for (int ty = 0; ty < (SCR_H + SPR_H - 1) / SPR_H; ty++)
        for (int tx = 0; tx < (SCR_W + SPR_W - 1) / SPR_W; tx++)
          model_sprite(tx * SPR_W, ty * SPR_H, sel, tr, k);
      lat = k + 2;
    end else begin
      lat = 1;
    end
    n = exp_q.size();
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] m, input int bx,
                         input int by, input int sel, input int fill,
                         input bit tr, input bit poke);
    int n, lat;
    model_cmd(m, bx, by, sel, fill, tr, n, lat);
    @(negedge clk); #1;
    wr_cnt = 0;
    done_cnt = 0;
    base_cyc = cyc + 1;
    mode = m;
    base_x = XW'(bx);
    base_y = YW'(by);
    sprite_sel = SEL_W'(sel);
    fill_colour = CW'(fill);
    transp_en = tr;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_rise"}, 64'(busy), 64'd1);
    // Command fields may change freely once captured.
    base_x = XW'($urandom);
    base_y = YW'($urandom);
    sprite_sel = SEL_W'($urandom);
    fill_colour = CW'($urandom);
    transp_en = 1'($urandom);
    for (int i = 0; i < lat + 20 && done_cnt == 0; i++) begin
      if (poke && i == 40) begin
        mode = MODE_CLEAR;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk); #1;
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    check({tag, "_done_time"}, 64'(done_cyc - base_cyc), 64'(lat));
    check({tag, "_write_count"}, 64'(wr_cnt), 64'(n));
    check({tag, "_leftover"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_busy_fall"}, 64'(busy), 64'd0);
    exp_q.delete();
  endtask

  task automatic reset_abort();
    int n, lat;
    model_cmd(MODE_BLIT, 8, 4, 0, 0, 1'b0, n, lat);
    @(negedge clk); #1;
    wr_cnt = 0;
    base_cyc = cyc + 1;
    mode = MODE_BLIT;
    base_x = 9'd8;
    base_y = 8'd4;
    sprite_sel = '0;
    transp_en = 1'b0;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (60) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_outputs_zero",
          64'({busy, done, writeEn, X, Y, Colour, rom_addr}), 64'd0);
    check("abort_had_writes", 64'(wr_cnt > 0), 64'd1);
    exp_q.delete();
    wr_cnt = 0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    repeat (300) @(negedge clk);
    #1;
    check("abort_no_writes", 64'(wr_cnt), 64'd0);
    check("abort_idle", 64'({busy, done}), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = CW'(i + 1);
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state",
          64'({busy, done, writeEn, X, Y, Colour, rom_addr}), 64'd0);
    #1 reset = 1'b1;

    run_cmd("clear", MODE_CLEAR, 0, 0, 0, 15'h7C00, 1'b0, 1'b0);
    run_cmd("blit_ramp", MODE_BLIT, 20, 10, 0, 0, 1'b0, 1'b0);
    run_cmd("blit_clip", MODE_BLIT, SCR_W - 10, SCR_H - 10, 1, 0, 1'b0, 1'b0);

    // Sprite 2: 64 key words at distinct positions, all others non-key.
    for (int i = 0; i < 256; i++) rom[512 + i] = CW'($urandom_range(1, 32767));
    for (int j = 0; j < 64; j++) rom[512 + j * 4 + $urandom_range(0, 3)] = KEY;
    run_cmd("blit_key_on", MODE_BLIT, 30, 5, 2, 0, 1'b1, 1'b0);
    run_cmd("blit_key_off", MODE_BLIT, 30, 5, 2, 0, 1'b0, 1'b0);

    run_cmd("blit_nowrap_xy", MODE_BLIT, 511, 255, 0, 0, 1'b0, 1'b0);
    run_cmd("blit_nowrap_x", MODE_BLIT, 500, 3, 1, 0, 1'b0, 1'b0);
    run_cmd("reserved", MODE_RSVD, 0, 0, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < (1 << AW); i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? KEY : CW'($urandom);
    run_cmd("tile", MODE_TILE, 0, 0, $urandom_range(0, 3), 0, 1'b1, 1'b0);

    for (int r = 0; r < 6; r++)
      run_cmd("blit_rand", MODE_BLIT, $urandom_range(0, SCR_W + 20),
              $urandom_range(0, SCR_H + 20), $urandom_range(0, 3), 0,
              1'($urandom), 1'b0);

    run_cmd("blit_poke", MODE_BLIT, 10, 10, 3, 0, 1'b1, 1'b1);
    reset_abort();
    run_cmd("blit_after_reset", MODE_BLIT, 40, 20, 1, 0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
Parametrised pixel engine for the VGA framebuffer path that replaces the fixed-size draw logic in the game datapath. It does a full-screen clear, a sprite blit at any (x,y), or a background tile fill from a single sprite ROM. It applies a transparency key and clips to screen bounds. It emits one pixel write per clock to the VGA adapter (X, Y, Colour, writeEn) and uses a start/busy/done handshake with the game FSM.

Parameters:
SCR_W, 320, screen width in pixels
SCR_H, 240, screen height in pixels
XW, 9, X coordinate width
YW, 8, Y coordinate width
CW, 15, colour width (5:5:5)
SPR_W, 16, sprite width (power of 2)
SPR_H, 16, sprite height (power of 2)
SEL_W, 2, sprite-select width (ROM holds 2**SEL_W sprites)
KEY, 15'h0000, transparent colour value

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
start  in  1  command strobe, sampled only in IDLE
mode  in  2  0=CLEAR, 1=BLIT, 2=TILE, 3=reserved
base_x  in  XW  BLIT origin X
base_y  in  YW  BLIT origin Y
sprite_sel  in  SEL_W  sprite index
fill_colour  in  CW  CLEAR colour
transp_en  in  1  suppress pixels equal to KEY
rom_addr  out  SEL_W+log2(SPR_W*SPR_H)  sprite ROM address = {sprite_sel, py, px}
rom_data  in  CW  ROM data, valid 1 cycle after rom_addr
busy  out  1  command in progress
done  out  1  one-cycle completion pulse
writeEn  out  1  pixel write strobe
X  out  XW  pixel X
Y  out  YW  pixel Y
Colour  out  CW  pixel colour

Behaviour:
- Reset (asynchronous, active-low): state IDLE. busy, done, writeEn, X, Y, Colour and rom_addr are 0. Reset mid-command aborts with no further writes.
- States: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- Command capture: start=1 in IDLE latches mode, base_x, base_y, sprite_sel, fill_colour and transp_en. busy rises the next cycle. start while busy is ignored. Inputs may change freely after capture.
- CLEAR: X/Y raster across SCR_W x SCR_H, X fastest. One write per cycle with Colour=fill_colour, no ROM access, no transparency. The first write appears 1 cycle after busy rises. Exactly SCR_W*SCR_H writes.
- BLIT: counters px/py scan SPR_W x SPR_H. rom_addr is issued in RUN. The matching write is 1 cycle later (DRAIN covers the last pixel), with X=base_x+px and Y=base_y+py.
- BLIT widths: the sum is computed at XW+1 / YW+1 bits, with no wrap-around. If X>=SCR_W or Y>=SCR_H, writeEn=0 but the cycle is still consumed.
- TILE: tile counters tx/ty step across ceil(SCR_W/SPR_W) x ceil(SCR_H/SPR_H) tiles, tx fastest. Each tile is a full sprite scan at origin (tx*SPR_W, ty*SPR_H), with the same clipping as BLIT.
- Transparency (BLIT/TILE): if transp_en=1 and rom_data==KEY, writeEn=0 and X/Y/Colour still update.
- Cycle count: every mode spends exactly one cycle per scanned pixel, whatever the suppression.
- done: pulses high for exactly 1 cycle in DONE, the cycle after the last write slot. busy falls in that same cycle, and a new start is accepted the following cycle.
- mode=3: busy for 1 cycle, then a done pulse, with zero writes.
- Outputs are registered. X/Y/Colour hold their last value while writeEn=0 in IDLE.

Decomposition:
- Shared package blit_pkg holds the mode constants (MODE_CLEAR, MODE_BLIT, MODE_TILE), the state encoding, and the default screen/colour width constants shared with the VGA adapter instance.
- One sub-module, blit_scan_gen: the nested px/py/tx/ty counter with a last-pixel flag, parametrised on SPR_W, SPR_H and the tile counts. The top level holds the FSM, the ROM-latency pipeline register, clipping and transparency.

Test Plan:
- CLEAR, fill_colour=15'h7C00 -> exactly 76800 writes, all red. First write is (0,0), last is (319,239). done pulses once, 1 cycle after the last write.
- BLIT at (100,50) with a ROM ramp (data=address+1), transp_en=0 -> 256 writes. Pixel (px,py) lands at (100+px,50+py) with Colour=py*16+px+1. done arrives 258 cycles after start.
- BLIT at (310,230) -> only the 10x10 in-bounds pixels are written (100 writes). Total busy duration is unchanged from the unclipped case.
- BLIT with 64 ROM words = KEY and transp_en=1 -> 192 writes, none at the key-pixel coordinates. With transp_en=0, all 256 are written.
- TILE with a 16x16 sprite -> 300 tiles, 76800 writes. Pixel (x,y) has Colour=ROM[y%16*16+x%16].
- Second start during BLIT is ignored. Reset asserted mid-BLIT -> all outputs 0 immediately (asynchronous), and there are no writes until the next start after release.
